// File: rtl/i2c_mem_target.sv
// i2c_mem_target
// Serial memory target on an open-drain two-wire bus. A frame is
// START, ADDRWIDTH address bits (MSB first), an R/W bit (0 = write,
// 1 = read), an ACK slot driven by this target, one data byte and STOP.
// Writes land in an internal 2**ADDRWIDTH x DATAWIDTH memory; reads shift
// the addressed word back out MSB first. The target only ever pulls sda
// low or releases it.
//
// Ports
//   clk_i      system clock, all logic on its rising edge
//   reset_i    asynchronous active-high reset (aborts any frame in flight)
//   scl_i      bus clock from the controller, level-sampled
//   sda_io     open-drain bus data, driven 0 or released to z
//   busy_o     high from START until STOP (or abort)
//   wr_done_o  one-cycle pulse when a write byte is committed to memory
//   rd_done_o  one-cycle pulse when the last read bit has been released

module i2c_mem_target #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 6
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic scl_i,
  inout  wire  sda_io,
  output logic busy_o,
  output logic wr_done_o,
  output logic rd_done_o
);

  localparam int DEPTH = 1 << ADDRWIDTH;
  // The counter has to reach both the data width and the address+R/W
  // count, so it is sized for whichever is larger.
  localparam int MAXBITS = (DATAWIDTH > ADDRWIDTH + 1) ? DATAWIDTH : ADDRWIDTH + 1;
  localparam int CNTW = $clog2(MAXBITS + 1);
  localparam logic [CNTW-1:0] ADDR_BITS = CNTW'(ADDRWIDTH + 1);
  localparam logic [CNTW-1:0] DATA_BITS = CNTW'(DATAWIDTH);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_A,
    WDATA,
    ACK_D,
    RDATA,
    WAIT_STOP
  } state_t;

  state_t state_q, state_d;
  logic [CNTW-1:0] bitCnt_q, bitCnt_d;
  logic [ADDRWIDTH:0] addrShift_q, addrShift_d;
  logic [DATAWIDTH-1:0] rxShift_q, rxShift_d;
  logic [DATAWIDTH-1:0] txShift_q, txShift_d;
  logic sdaOe_q, sdaOe_d;
  logic wrDone_q, wrDone_d;
  logic rdDone_q, rdDone_d;
  logic memWe;
  logic [DATAWIDTH-1:0] mem_q [DEPTH];

  logic sclMeta_q, sclSync_q, sclPrev_q;
  logic sdaMeta_q, sdaSync_q, sdaPrev_q;
  logic sclRise, sclFall, startSeen, stopSeen;
  logic [ADDRWIDTH-1:0] frameAddr;
  logic frameRead;

  assign sda_io = sdaOe_q ? 1'b0 : 1'bz;
  assign busy_o = (state_q != IDLE);
  assign wr_done_o = wrDone_q;
  assign rd_done_o = rdDone_q;

  assign frameAddr = addrShift_q[ADDRWIDTH:1];
  assign frameRead = addrShift_q[0];

  // Two-flop synchronisers plus a third "previous" flop for edge detection.
  // They reset to 1 (idle bus level) so leaving reset never fakes an event.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sclMeta_q <= 1'b1;
      sclSync_q <= 1'b1;
      sclPrev_q <= 1'b1;
      sdaMeta_q <= 1'b1;
      sdaSync_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclMeta_q <= scl_i;
      sclSync_q <= sclMeta_q;
      sclPrev_q <= sclSync_q;
      sdaMeta_q <= sda_io;
      sdaSync_q <= sdaMeta_q;
      sdaPrev_q <= sdaSync_q;
    end
  end

  // START/STOP need scl stably high across the sda edge, and are ignored
  // while we are pulling sda ourselves.
  assign sclRise   = sclSync_q & ~sclPrev_q;
  assign sclFall   = ~sclSync_q & sclPrev_q;
  assign startSeen = sclSync_q & sclPrev_q & sdaPrev_q & ~sdaSync_q & ~sdaOe_q;
  assign stopSeen  = sclSync_q & sclPrev_q & ~sdaPrev_q & sdaSync_q & ~sdaOe_q;

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      addrShift_q <= '0;
      rxShift_q   <= '0;
      txShift_q   <= '0;
      sdaOe_q     <= 1'b0;
      wrDone_q    <= 1'b0;
      rdDone_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      addrShift_q <= addrShift_d;
      rxShift_q   <= rxShift_d;
      txShift_q   <= txShift_d;
      sdaOe_q     <= sdaOe_d;
      wrDone_q    <= wrDone_d;
      rdDone_q    <= rdDone_d;
    end
  end

  // Storage array; cleared by reset so unwritten words read back as zero.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (memWe) begin
      mem_q[frameAddr] <= rxShift_q;
    end
  end

  // Frame sequencer. STOP and START override every state; otherwise bits
  // are sampled on scl rise and sda is only changed on scl fall.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    addrShift_d = addrShift_q;
    rxShift_d   = rxShift_q;
    txShift_d   = txShift_q;
    sdaOe_d     = sdaOe_q;
    wrDone_d    = 1'b0;
    rdDone_d    = 1'b0;
    memWe       = 1'b0;

    if (state_q != IDLE && stopSeen) begin
      state_d  = IDLE;
      sdaOe_d  = 1'b0;
      bitCnt_d = '0;
    end else if (startSeen) begin
      state_d  = ADDR;
      sdaOe_d  = 1'b0;
      bitCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          sdaOe_d = 1'b0;
        end
        ADDR: begin
          if (sclRise && bitCnt_q < ADDR_BITS) begin
            addrShift_d = {addrShift_q[ADDRWIDTH-1:0], sdaSync_q};
            bitCnt_d    = bitCnt_q + CNTW'(1);
          end else if (sclFall && bitCnt_q == ADDR_BITS) begin
            sdaOe_d  = 1'b1;
            bitCnt_d = '0;
            state_d  = ACK_A;
          end
        end
        ACK_A: begin
          if (sclFall) begin
            if (frameRead) begin
              // The MSB goes out on the same fall that ends the ACK.
              txShift_d = mem_q[frameAddr];
              sdaOe_d   = ~mem_q[frameAddr][DATAWIDTH-1];
              bitCnt_d  = CNTW'(1);
              state_d   = RDATA;
            end else begin
              sdaOe_d  = 1'b0;
              bitCnt_d = '0;
              state_d  = WDATA;
            end
          end
        end
        WDATA: begin
          if (sclRise && bitCnt_q < DATA_BITS) begin
            rxShift_d = {rxShift_q[DATAWIDTH-2:0], sdaSync_q};
            bitCnt_d  = bitCnt_q + CNTW'(1);
          end else if (sclFall && bitCnt_q == DATA_BITS) begin
            memWe    = 1'b1;
            wrDone_d = 1'b1;
            sdaOe_d  = 1'b1;
            bitCnt_d = '0;
            state_d  = ACK_D;
          end
        end
        ACK_D: begin
          if (sclFall) begin
            sdaOe_d = 1'b0;
            state_d = WAIT_STOP;
          end
        end
        RDATA: begin
          if (sclFall) begin
            if (bitCnt_q == DATA_BITS) begin
              // Controller's ACK/NACK slot follows; we simply stay off the bus.
              sdaOe_d  = 1'b0;
              rdDone_d = 1'b1;
              bitCnt_d = '0;
              state_d  = WAIT_STOP;
            end else begin
              sdaOe_d   = ~txShift_q[DATAWIDTH-2];
              txShift_d = {txShift_q[DATAWIDTH-2:0], 1'b0};
              bitCnt_d  = bitCnt_q + CNTW'(1);
            end
          end
        end
        WAIT_STOP: begin
          sdaOe_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          sdaOe_d = 1'b0;
        end
      endcase
    end
  end

endmodule
